// File: rtl/scan_decoder.sv
// scan_decoder: registered active-low one-hot decoder with an autonomous
// scan mode (programmable dwell, optional one-cycle blanking between channels).
module scan_decoder #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    G_L,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   Y_L,
  output logic [SEL_W-1:0]        cur,
  output logic                    wrap
);

  localparam int unsigned N      = 1 << SEL_W;
  localparam int unsigned DCNT_W = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        y_q, y_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                wrap_q, wrap_d;
  logic [SEL_W-1:0]    next_idx;

  // Active-low one-hot decode of an index.
  function automatic logic [N-1:0] dec_l(input logic [SEL_W-1:0] idx);
    logic [N-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  assign next_idx = cur_q + SEL_W'(1);

  // Next-state and registered-output logic; priority G_L over mode.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cur_d   = cur_q;
    dcnt_d  = dcnt_q;
    wrap_d  = 1'b0;
    if (G_L) begin
      state_d = IDLE;
      y_d     = '1;
      dcnt_d  = '0;
    end else if (!mode) begin
      state_d = DIRECT;
      cur_d   = sel;
      y_d     = dec_l(sel);
      dcnt_d  = '0;
    end else begin
      case (state_q)
        SCAN_ON: begin
          if (dcnt_q < DCNT_W'(DWELL)) begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end else if (BLANK != 0) begin
            state_d = SCAN_BLANK;
            y_d     = '1;
            dcnt_d  = '0;
          end else begin
            cur_d  = next_idx;
            y_d    = dec_l(next_idx);
            dcnt_d = DCNT_W'(1);
            wrap_d = &cur_q;
          end
        end
        SCAN_BLANK: begin
          // cur is held through blanking, so it still names the old channel.
          state_d = SCAN_ON;
          cur_d   = next_idx;
          y_d     = dec_l(next_idx);
          dcnt_d  = DCNT_W'(1);
          wrap_d  = &cur_q;
        end
        default: begin
          // Scan entry from IDLE or DIRECT: restart at sel with a full dwell.
          state_d = SCAN_ON;
          cur_d   = sel;
          y_d     = dec_l(sel);
          dcnt_d  = DCNT_W'(1);
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '1;
      cur_q   <= '0;
      dcnt_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cur_q   <= cur_d;
      dcnt_q  <= dcnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y_L  = y_q;
  assign cur  = cur_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three instances (DWELL/BLANK = 3/0, 2/1, 1/0) share
// one stimulus stream; expectations are queued per cycle and checked after
// the following clock edge.
module tb_scan_decoder;

  localparam int unsigned NDUT = 3;
  localparam int unsigned DW [NDUT] = '{3, 2, 1};
  localparam int unsigned BL [NDUT] = '{0, 1, 0};

  typedef struct packed {
    logic [NDUT-1:0][3:0] y;
    logic [NDUT-1:0][1:0] c;
    logic [NDUT-1:0]      w;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, G_L, mode;
  logic [1:0] sel;
  logic [3:0] y_o [NDUT];
  logic [1:0] c_o [NDUT];
  logic       w_o [NDUT];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  exp_t        exp_q [$];
  string       tag_q [$];
  exp_t        last_e;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(2), .DWELL(3), .BLANK(0)) dut_a (
    .clk(clk), .reset(reset), .G_L(G_L), .mode(mode), .sel(sel),
    .Y_L(y_o[0]), .cur(c_o[0]), .wrap(w_o[0]));
  scan_decoder #(.SEL_W(2), .DWELL(2), .BLANK(1)) dut_b (
    .clk(clk), .reset(reset), .G_L(G_L), .mode(mode), .sel(sel),
    .Y_L(y_o[1]), .cur(c_o[1]), .wrap(w_o[1]));
  scan_decoder #(.SEL_W(2), .DWELL(1), .BLANK(0)) dut_c (
    .clk(clk), .reset(reset), .G_L(G_L), .mode(mode), .sel(sel),
    .Y_L(y_o[2]), .cur(c_o[2]), .wrap(w_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Same non-scan outputs on every instance.
  function automatic exp_t e_all(input logic [3:0] y, input logic [1:0] c);
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      e.y[i] = y; e.c[i] = c; e.w[i] = 1'b0;
    end
    return e;
  endfunction

  // Disabled: strobes inactive, index held from the previous cycle.
  function automatic exp_t e_idle();
    exp_t e;
    e = last_e;
    for (int i = 0; i < NDUT; i++) begin
      e.y[i] = 4'hF; e.w[i] = 1'b0;
    end
    return e;
  endfunction

  // Closed-form scan output c cycles after entry at start index s.
  function automatic exp_t e_scan(input logic [1:0] s, input int unsigned c);
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      int unsigned p, slot, pos;
      logic [1:0]  ch;
      p    = DW[i] + BL[i];
      slot = c / p;
      pos  = c % p;
      ch   = 2'(int'(s) + int'(slot));
      e.c[i] = ch;
      e.y[i] = (pos >= DW[i]) ? 4'hF : ~(4'b0001 << ch);
      e.w[i] = (pos == 0) && (slot > 0) && (ch == 2'd0);
    end
    return e;
  endfunction

  // Queue the expectation for the next edge, then compare after it.
  task automatic cyc(input string tag, input exp_t e);
    exp_t  got_e;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    last_e = e;
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    t     = tag_q.pop_front();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s.y%0d", t, i), 32'(y_o[i]), 32'(got_e.y[i]));
      check($sformatf("%s.cur%0d", t, i), 32'(c_o[i]), 32'(got_e.c[i]));
      check($sformatf("%s.wrap%0d", t, i), 32'(w_o[i]), 32'(got_e.w[i]));
    end
  endtask

  initial begin
    reset = 1'b1; G_L = 1'b0; mode = 1'b1; sel = 2'd2;

    // Reset dominates a pending scan request.
    for (int k = 0; k < 2; k++) cyc($sformatf("rst%0d", k), e_all(4'hF, 2'd0));
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rel.y%0d", i), 32'(y_o[i]), 32'hF);
      check($sformatf("rel.cur%0d", i), 32'(c_o[i]), 32'h0);
      check($sformatf("rel.wrap%0d", i), 32'(w_o[i]), 32'h0);
    end

    // Scan from sel=2 over more than a frame; sel changes are ignored.
    for (int unsigned k = 0; k < 14; k++) begin
      cyc($sformatf("scan2_%0d", k), e_scan(2'd2, k));
      sel = 2'd1;
    end

    // Direct decode of every index, then disable.
    mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] s;
      s   = 2'(k);
      sel = s;
      cyc($sformatf("dir%0d", k), e_all(~(4'b0001 << s), s));
    end
    G_L = 1'b1;
    cyc("dis", e_idle());

    // Scan from sel=0: no wrap on entry, wrap after channel 3.
    G_L = 1'b0; mode = 1'b1; sel = 2'd0;
    for (int unsigned k = 0; k < 16; k++) cyc($sformatf("scan0_%0d", k), e_scan(2'd0, k));

    // Mid-dwell disable, then re-entry at sel=3 with a full dwell.
    G_L = 1'b1;
    cyc("gap", e_idle());
    G_L = 1'b0; sel = 2'd1;
    for (int unsigned k = 0; k < 2; k++) cyc($sformatf("ch1_%0d", k), e_scan(2'd1, k));
    G_L = 1'b1;
    cyc("middis", e_idle());
    G_L = 1'b0; sel = 2'd3;
    for (int unsigned k = 0; k < 4; k++) cyc($sformatf("scan3_%0d", k), e_scan(2'd3, k));

    // Mode drop mid-scan goes straight to direct decode.
    mode = 1'b0; sel = 2'd1;
    cyc("modesw", e_all(4'b1101, 2'd1));

    // Reset while the blanking instance sits in its blank cycle.
    mode = 1'b1; sel = 2'd0;
    for (int unsigned k = 0; k < 3; k++) cyc($sformatf("pre_%0d", k), e_scan(2'd0, k));
    reset = 1'b1;
    cyc("rstblank", e_all(4'hF, 2'd0));
    reset = 1'b0; sel = 2'd3;
    for (int unsigned k = 0; k < 4; k++) cyc($sformatf("post_%0d", k), e_scan(2'd3, k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
